victim_wb_buffer: RTL and testbench

Write-back buffer and victim MSHR sitting directly downstream of the 4-way L1 data cache. It captures the dirty victim line words that the cache streams out during a miss refill, queues up to `ENTRIES` complete lines, and drains them word-by-word to memory over a req/ack handshake. While a line is pending it also answers cache lookups, so a re-miss on an evicted line never reads stale memory.

---
 rtl/victim_wb_buffer_pkg.sv | 21 ++
 rtl/victim_line_slot.sv | 61 ++++++
 rtl/victim_wb_buffer.sv | 186 ++++++++++++++++++
 tb/tb_victim_wb_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_wb_buffer_pkg.sv
// Shared L1 data cache definitions: address slicing, line width, drain states.
package victim_wb_buffer_pkg;

    localparam int ADR_W        = 32;
    localparam int BYTE_OFS_LSB = 0;
    localparam int BYTE_OFS_W   = 2;
    localparam int WORD_OFS_LSB = 2;
    localparam int WORD_OFS_W   = 2;
    localparam int INDEX_LSB    = 4;
    localparam int INDEX_W      = 6;
    localparam int TAG_LSB      = INDEX_LSB + INDEX_W;
    localparam int TAG_W        = ADR_W - TAG_LSB;
    localparam int LINE_LSB     = INDEX_LSB;
    localparam int LINE_ADR_W   = ADR_W - LINE_LSB;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/victim_line_slot.sv
// One buffered victim line: words, captured-word mask, valid, lookup match.
module victim_line_slot
    import victim_wb_buffer_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int LINE_W            = LINE_ADR_W,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WORD_NUM          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [WORD_OFFSET_WIDTH-1:0] we_word,
    input  logic [WORD_WIDTH-1:0]        we_dat,
    input  logic                         commit,
    input  logic [LINE_W-1:0]            commit_line,
    input  logic                         inval,
    input  logic [LINE_W-1:0]            lookup_line,
    input  logic [WORD_OFFSET_WIDTH-1:0] lookup_word,
    input  logic [WORD_OFFSET_WIDTH-1:0] rd_word,
    output logic [LINE_W-1:0]            line,
    output logic                         complete,
    output logic                         match,
    output logic [WORD_WIDTH-1:0]        lookup_dat,
    output logic [WORD_WIDTH-1:0]        rd_dat
);

    logic                                 valid;
    logic [WORD_NUM-1:0]                  mask;
    logic [WORD_NUM-1:0]                  we_bit;
    logic [WORD_NUM-1:0][WORD_WIDTH-1:0]  words;

    // a word captured in the commit cycle still counts toward completeness
    assign we_bit     = we ? (WORD_NUM'(1) << we_word) : '0;
    assign complete   = &(mask | we_bit);
    assign match      = valid && (line == lookup_line);
    assign lookup_dat = words[lookup_word];
    assign rd_dat     = words[rd_word];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            mask  <= '0;
            line  <= '0;
            words <= '0;
        end else begin
            if (we)
                words[we_word] <= we_dat;
            if (commit) begin
                valid <= 1'b1;
                line  <= commit_line;
                mask  <= '0;
            end else if (we) begin
                mask <= mask | we_bit;
            end
            if (inval)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/victim_wb_buffer.sv
// Victim write-back buffer: FIFO of dirty lines, word drain, victim lookup.
module victim_wb_buffer
    import victim_wb_buffer_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int ADR_WIDTH         = 32,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WORD_NUM          = 4,
    parameter int ENTRIES           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         victim_we_i,
    input  logic [WORD_OFFSET_WIDTH-1:0] victim_word_i,
    input  logic [WORD_WIDTH-1:0]        victim_dat_i,
    input  logic                         victim_commit_i,
    input  logic [ADR_WIDTH-1:0]         victim_adr_i,
    output logic                         victim_ready_o,
    output logic                         overflow_o,
    output logic                         wb_req_o,
    output logic [ADR_WIDTH-1:0]         wb_adr_o,
    output logic [WORD_WIDTH-1:0]        wb_dat_o,
    input  logic                         wb_ack_i,
    input  logic [ADR_WIDTH-1:0]         lookup_adr_i,
    output logic                         lookup_hit_o,
    output logic [WORD_WIDTH-1:0]        lookup_dat_o
);

    localparam int LINE_W = ADR_WIDTH - LINE_LSB;
    localparam int PTR_W  = $clog2(ENTRIES);
    localparam int CNT_W  = $clog2(ENTRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD =
        WORD_OFFSET_WIDTH'(WORD_NUM - 1);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;
    drain_state_t                 state;
    logic [WORD_OFFSET_WIDTH-1:0] cnt;

    logic                         full;
    logic                         fill_we;
    logic                         commit_ok;
    logic                         last_ack;
    logic [WORD_OFFSET_WIDTH-1:0] rd_word;
    logic [LINE_W-1:0]            commit_line;
    logic [LINE_W-1:0]            lookup_line;
    logic [WORD_OFFSET_WIDTH-1:0] lookup_word;
    logic [LINE_W-1:0]            rd_line;
    logic [WORD_WIDTH-1:0]        rd_dat;
    logic                         hit_n;
    logic [WORD_WIDTH-1:0]        dat_n;
    logic                         unused;

    logic [ENTRIES-1:0]           slot_complete;
    logic [ENTRIES-1:0]           slot_match;
    logic [LINE_W-1:0]            slot_line   [ENTRIES];
    logic [WORD_WIDTH-1:0]        slot_rd_dat [ENTRIES];
    logic [WORD_WIDTH-1:0]        slot_lk_dat [ENTRIES];

    assign full           = (count == FULL_CNT);
    assign victim_ready_o = !full;
    assign fill_we        = victim_we_i && !full;
    assign commit_ok      = victim_commit_i && !full;
    assign last_ack       = (state == DRAIN_REQ) && wb_ack_i
                            && (cnt == LAST_WORD);
    assign rd_word        = (state == DRAIN_REQ)
                            ? cnt + WORD_OFFSET_WIDTH'(1) : '0;
    assign commit_line    = victim_adr_i[ADR_WIDTH-1:LINE_LSB];
    assign lookup_line    = lookup_adr_i[ADR_WIDTH-1:LINE_LSB];
    assign lookup_word    = lookup_adr_i[WORD_OFS_LSB +: WORD_OFFSET_WIDTH];
    assign rd_line        = slot_line[rd_ptr];
    assign rd_dat         = slot_rd_dat[rd_ptr];
    assign unused = ^{victim_adr_i[LINE_LSB-1:0],
                      lookup_adr_i[WORD_OFS_LSB-1:0]};

    for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
        victim_line_slot #(
            .WORD_WIDTH       (WORD_WIDTH),
            .LINE_W           (LINE_W),
            .WORD_OFFSET_WIDTH(WORD_OFFSET_WIDTH),
            .WORD_NUM         (WORD_NUM)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .we         (fill_we && (wr_ptr == PTR_W'(g))),
            .we_word    (victim_word_i),
            .we_dat     (victim_dat_i),
            .commit     (commit_ok && (wr_ptr == PTR_W'(g))),
            .commit_line(commit_line),
            .inval      (last_ack && (rd_ptr == PTR_W'(g))),
            .lookup_line(lookup_line),
            .lookup_word(lookup_word),
            .rd_word    (rd_word),
            .line       (slot_line[g]),
            .complete   (slot_complete[g]),
            .match      (slot_match[g]),
            .lookup_dat (slot_lk_dat[g]),
            .rd_dat     (slot_rd_dat[g])
        );
    end

    // walk oldest to newest so the newest matching line wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = '0;
        hit_n = 1'b0;
        dat_n = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (slot_match[idx]) begin
                hit_n = 1'b1;
                dat_n = slot_lk_dat[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookup_hit_o <= 1'b0;
            lookup_dat_o <= '0;
        end else begin
            lookup_hit_o <= hit_n;
            lookup_dat_o <= dat_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (commit_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (last_ack)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({commit_ok, last_ack})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (((victim_we_i || victim_commit_i) && full)
                || (commit_ok && !slot_complete[wr_ptr]))
                overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DRAIN_IDLE;
            cnt      <= '0;
            wb_req_o <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            unique case (state)
                DRAIN_IDLE: begin
                    if (count != '0) begin
                        state    <= DRAIN_REQ;
                        cnt      <= '0;
                        wb_req_o <= 1'b1;
                        wb_adr_o <= ADR_WIDTH'({rd_line, rd_word, 2'b00});
                        wb_dat_o <= rd_dat;
                    end
                end
                DRAIN_REQ: begin
                    if (wb_ack_i) begin
                        if (cnt == LAST_WORD) begin
                            state    <= DRAIN_IDLE;
                            wb_req_o <= 1'b0;
                        end else begin
                            cnt      <= rd_word;
                            wb_adr_o <= ADR_WIDTH'({rd_line, rd_word, 2'b00});
                            wb_dat_o <= rd_dat;
                        end
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Randomized bench for victim_wb_buffer against a queue-based line model.
module tb_victim_wb_buffer;

    localparam int ENTRIES = 2;

    typedef struct {
        logic [27:0]      line;
        logic [3:0][31:0] w;
        logic [3:0]       known;
    } line_t;

    logic        clk;
    logic        rst;
    logic        victim_we_i;
    logic [1:0]  victim_word_i;
    logic [31:0] victim_dat_i;
    logic        victim_commit_i;
    logic [31:0] victim_adr_i;
    logic        victim_ready_o;
    logic        overflow_o;
    logic        wb_req_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic [31:0] lookup_adr_i;
    logic        lookup_hit_o;
    logic [31:0] lookup_dat_o;

    victim_wb_buffer #(
        .WORD_WIDTH       (32),
        .ADR_WIDTH        (32),
        .WORD_OFFSET_WIDTH(2),
        .WORD_NUM         (4),
        .ENTRIES          (ENTRIES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .victim_we_i    (victim_we_i),
        .victim_word_i  (victim_word_i),
        .victim_dat_i   (victim_dat_i),
        .victim_commit_i(victim_commit_i),
        .victim_adr_i   (victim_adr_i),
        .victim_ready_o (victim_ready_o),
        .overflow_o     (overflow_o),
        .wb_req_o       (wb_req_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_i       (wb_ack_i),
        .lookup_adr_i   (lookup_adr_i),
        .lookup_hit_o   (lookup_hit_o),
        .lookup_dat_o   (lookup_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    line_t       q[$];
    bit          m_busy;
    int          m_widx;
    logic [31:0] fw[4];
    logic [3:0]  fm;
    bit          m_ovf;
    bit          e_hit;
    bit          e_lknown;
    logic [31:0] e_ldat;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_widx = 0;
        fm     = 4'h0;
        m_ovf  = 0;
        e_hit  = 0;
    endtask

    // one clock edge of the spec-level behaviour, pre-edge state as input
    task automatic model_step(input bit we, input int word,
                              input logic [31:0] dat, input bit commit,
                              input logic [31:0] adr, input bit ack,
                              input logic [31:0] lk);
        bit    full;
        int    lw;
        line_t n;
        full     = (q.size() == ENTRIES);
        lw       = int'(lk[3:2]);
        e_hit    = 0;
        e_lknown = 0;
        foreach (q[i]) begin
            if (q[i].line == lk[31:4]) begin
                e_hit    = 1;
                e_ldat   = q[i].w[lw];
                e_lknown = q[i].known[lw];
            end
        end
        if (m_busy) begin
            if (ack) begin
                if (m_widx == 3) begin
                    q.delete(0);
                    m_busy = 0;
                end else begin
                    m_widx++;
                end
            end
        end else if (q.size() > 0) begin
            m_busy = 1;
            m_widx = 0;
        end
        if ((we || commit) && full) begin
            m_ovf = 1;
        end else begin
            if (we) begin
                fw[word] = dat;
                fm[word] = 1'b1;
            end
            if (commit) begin
                if (fm != 4'hF) m_ovf = 1;
                n.line  = adr[31:4];
                for (int k = 0; k < 4; k++) n.w[k] = fw[k];
                n.known = fm;
                q.push_back(n);
                fm = 4'h0;
            end
        end
    endtask

    task automatic cyc(input bit we, input int word, input logic [31:0] dat,
                       input bit commit, input logic [31:0] adr,
                       input bit ack, input logic [31:0] lk);
        logic [1:0] wi;
        wi = m_widx[1:0];
        victim_we_i     = we;
        victim_word_i   = word[1:0];
        victim_dat_i    = dat;
        victim_commit_i = commit;
        victim_adr_i    = adr;
        wb_ack_i        = ack;
        lookup_adr_i    = lk;
        model_step(we, word, dat, commit, adr, ack, lk);
        @(posedge clk);
        #1;
        wi = m_widx[1:0];
        chk("req", wb_req_o, m_busy);
        chk("ready", victim_ready_o, q.size() != ENTRIES);
        chk("ovf", overflow_o, m_ovf);
        chk("hit", lookup_hit_o, e_hit);
        if (e_hit && e_lknown) chk("ldat", lookup_dat_o, e_ldat);
        if (m_busy) begin
            chk("wadr", wb_adr_o, {q[0].line, wi, 2'b00});
            if (q[0].known[wi]) chk("wdat", wb_dat_o, q[0].w[wi]);
        end
    endtask

    task automatic fill_line(input logic [31:0] adr, input int start,
                             input logic [31:0] base, input bit ack,
                             input logic [31:0] lk);
        int wd;
        for (int k = 0; k < 4; k++) begin
            wd = (start + k) % 4;
            cyc(1, wd, base + 32'(wd), 0, 0, ack, lk);
        end
        cyc(0, 0, 0, 1, adr, ack, lk);
    endtask

    task automatic idle(input int n, input bit ack, input logic [31:0] lk);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, ack, lk);
    endtask

    initial begin
        int  fill_k;
        int  fill_start;
        bit  we;
        bit  commit;
        int  word;
        logic [31:0] adr;

        rst = 1'b0;
        victim_we_i = 0; victim_word_i = 0; victim_dat_i = 0;
        victim_commit_i = 0; victim_adr_i = 0; wb_ack_i = 0;
        lookup_adr_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_ready", victim_ready_o, 1);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_req", wb_req_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_hit", lookup_hit_o, 0);
        chk("rst_ldat", lookup_dat_o, 0);
        @(posedge clk);
        #1;

        // in-order line, acks every cycle, lookup hits then misses
        fill_line(32'h0000_1230, 0, 32'hA000_0000, 1, 32'h0000_1238);
        idle(8, 1, 32'h0000_1238);

        // wrapped capture order
        fill_line(32'h0000_4560, 2, 32'hB000_0000, 1, 32'h0000_4564);
        idle(8, 1, 32'h0000_456C);

        // fill both slots with ack held off, then a dropped third line
        fill_line(32'h0000_A000, 1, 32'hC000_0000, 0, 32'h0000_A008);
        fill_line(32'h0000_B000, 3, 32'hD000_0000, 0, 32'h0000_B004);
        fill_line(32'h0000_C000, 0, 32'hE000_0000, 0, 32'h0000_C000);
        idle(2, 0, 32'h0000_A00C);
        idle(14, 1, 32'h0000_B008);

        // async reset after the second ack of a line
        fill_line(32'h0000_7770, 0, 32'hF000_0000, 1, 32'h0000_7774);
        idle(3, 1, 32'h0000_7774);
        rst = 1'b0;
        #2;
        chk("arst_req", wb_req_o, 0);
        chk("arst_ready", victim_ready_o, 1);
        chk("arst_ovf", overflow_o, 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        idle(8, 1, 32'h0000_7774);

        // randomized traffic, commits only when a slot is free
        fill_k = 0;
        fill_start = 0;
        for (int it = 0; it < 400; it++) begin
            we = 0; commit = 0; word = 0; adr = 0;
            if (q.size() != ENTRIES) begin
                if (fill_k < 4 && $urandom_range(0, 3) != 0) begin
                    we = 1;
                    word = (fill_start + fill_k) % 4;
                    fill_k++;
                end
                if (fill_k == 4 && $urandom_range(0, 2) == 0) begin
                    commit = 1;
                    adr = 32'h0000_8000 + (32'($urandom_range(0, 3)) << 4);
                    fill_k = 0;
                    fill_start = $urandom_range(0, 3);
                end
            end
            cyc(we, word, $urandom, commit, adr,
                $urandom_range(0, 3) != 0,
                32'h0000_8000 + 32'($urandom_range(0, 19)) * 4);
        end
        idle(20, 1, 32'h0000_8000);

        // incomplete line commit flags overflow but still drains
        cyc(1, 1, 32'h1234_5678, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 32'h0000_9990, 1, 32'h0000_9994);
        idle(10, 1, 32'h0000_9994);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
